combo_sequencer: RTL and testbench
==================================

# combo_sequencer

Combination-entry sequencer sitting directly downstream of the dial direction decoder in the safebox. Each cycle it samples the raw 5-bit dial code and the decoded `direction` bit (1 = clockwise, 0 = anticlockwise). It takes the dial position at each direction reversal as an entered number and checks three entered numbers against a stored combination. Its outputs are `unlocked`, wrong-attempt tracking and a timed lockout.

## Interface
- CODE0, 5'd12, first number; entered by a clockwise→anticlockwise reversal
- CODE1, 5'd7, second number; entered by an anticlockwise→clockwise reversal
- CODE2, 5'd25, third number; entered by a clockwise→anticlockwise reversal
- OPEN_CYCLES, 64, cycles `unlocked` stays high without `lock`; legal range 1..65535
- MAX_FAIL, 3, wrong entries that trigger lockout; legal range 1..7
- LOCKOUT_CYCLES, 256, lockout duration in cycles; legal range 1..65535

- clock  input  1  system clock; all state changes on its rising edge
- n_reset  input  1  synchronous, active-low reset
- vault_code  input  5  raw dial position; the same signal that feeds the direction decoder
- direction  input  1  decoder output; 1 = clockwise, 0 = anticlockwise
- lock  input  1  relock request; level-sampled
- unlocked  output  1  safe open
- lockout  output  1  too many failures; dial input is ignored
- stage  output  2  progress: 0 = none, 1 = CODE0 accepted, 2 = CODE1 accepted, 3 = open
- fail_count  output  3  wrong entries since the last success or lockout exit

## Operation
- History registers:
  - code_q1 ← vault_code every cycle
  - code_q2 ← code_q1 every cycle
  - dir_q ← direction every cycle
  - prime counter 0→2, saturating
- Reversal event `rev` = (direction != dir_q) && prime == 2. The entered number is code_q2, i.e. the dial value before the step that caused the reversal. All 5-bit compares are exact and need no wrap handling.
- `rev_ccw` = rev && direction == 0. `rev_cw` = rev && direction == 1.
- IDLE (stage 0):
  - rev_ccw && code_q2 == CODE0 → GOT1
  - any other rev → stay IDLE; fail_count unchanged
- GOT1 (stage 1):
  - rev_cw && code_q2 == CODE1 → GOT2
  - rev with a wrong number → FAIL handling
- GOT2 (stage 2):
  - rev_ccw && code_q2 == CODE2 → OPEN; fail_count ← 0; timer ← 0
  - rev with a wrong number → FAIL handling
- FAIL handling:
  - if fail_count + 1 == MAX_FAIL → LOCKOUT; timer ← 0; fail_count ← MAX_FAIL
  - else fail_count increments and the state returns to IDLE
- OPEN (stage 3, unlocked = 1):
  - timer increments each cycle; reversals are ignored
  - lock == 1, or timer == OPEN_CYCLES-1 → IDLE
  - lock and timeout in the same cycle → IDLE (single transition)
- LOCKOUT (lockout = 1, stage 0):
  - all reversals are ignored; history registers keep updating
  - at timer == LOCKOUT_CYCLES-1 → IDLE; fail_count ← 0
  - `lock` has no effect
- Reset (n_reset = 0 at a rising edge):
  - state IDLE; unlocked 0; lockout 0; stage 0; fail_count 0; timer 0
  - code_q1 0; code_q2 0; dir_q 1; prime 0
  - a reset mid-sequence, mid-open or mid-lockout discards all progress

## Timing
- All outputs are registered and decoded from the state register; no combinational input→output path.
- Dial step causing a reversal is sampled at edge k → decoder flips `direction` at edge k → sequencer detects at edge k+1 → outputs update after edge k+1. Latency is 2 edges from the dial step.
- OPEN lasts exactly OPEN_CYCLES cycles without `lock`. If `lock` is high at the first OPEN edge, `unlocked` is high for 1 cycle.
- LOCKOUT lasts exactly LOCKOUT_CYCLES cycles.
- No reversal is detected on the first two edges after reset release.

## Test plan
- Correct entry:
  - stimulus: reset; count code 0→12 by +1 per cycle; reverse to 7; reverse to 25; reverse
  - required: stage 1 two edges after 12→11, stage 2 after 7→8, unlocked = 1 two edges after 25→24, unlocked = 0 after 64 cycles
- Wrong second number: enter 12 then reverse at 9 → state IDLE, fail_count = 1, unlocked never asserts.
- Lockout:
  - stimulus: three wrong second numbers
  - required: lockout = 1 after the third; a correct 12/7/25 sequence during lockout is ignored; lockout = 0 and fail_count = 0 after 256 cycles
- Relock: open the safe, assert lock for 1 cycle at timer = 10 → unlocked = 0 on the next edge, stage 0.
- Wrap-around: CODE0 = 0; count 30, 31, 0, then reverse (0→31) → entered number 0 → stage 1.
- Reset mid-sequence: reach stage 2, pull n_reset low for 1 edge → all outputs 0; an immediate dial step 25→24 is not detected.

Source files
------------

// File: rtl/combo_sequencer.sv
// Combination-entry sequencer: turns dial direction reversals into entered
// numbers, checks them against CODE0/1/2, and manages open time and lockout.
module combo_sequencer #(
  parameter logic [4:0]  CODE0          = 5'd12,
  parameter logic [4:0]  CODE1          = 5'd7,
  parameter logic [4:0]  CODE2          = 5'd25,
  parameter int unsigned OPEN_CYCLES    = 64,
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned LOCKOUT_CYCLES = 256
) (
  input  logic       clock,
  input  logic       n_reset,
  input  logic [4:0] vault_code,
  input  logic       direction,
  input  logic       lock,
  output logic       unlocked,
  output logic       lockout,
  output logic [1:0] stage,
  output logic [2:0] fail_count
);

  localparam logic [15:0] OPEN_LAST = 16'(OPEN_CYCLES - 1);
  localparam logic [15:0] LOCK_LAST = 16'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]  FAIL_MAX  = 3'(MAX_FAIL);
  localparam logic [2:0]  FAIL_LAST = 3'(MAX_FAIL - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GOT1    = 3'd1,
    ST_GOT2    = 3'd2,
    ST_OPEN    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  code1_q, code2_q;
  logic        dir_q;
  logic [1:0]  prime_q, prime_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  fail_q, fail_d;
  logic        unlocked_q, unlocked_d;
  logic        lockout_q, lockout_d;
  logic [1:0]  stage_q, stage_d;

  logic        rev_s, rev_ccw_s, rev_cw_s;
  state_t      fail_state_s;
  logic [2:0]  fail_next_s;

  // Reversal detection; the prime counter masks the first two edges after reset.
  always_comb begin
    rev_s     = (direction != dir_q) && (prime_q == 2'd2);
    rev_ccw_s = rev_s && (direction == 1'b0);
    rev_cw_s  = rev_s && (direction == 1'b1);
    if (prime_q == 2'd2) begin
      prime_d = prime_q;
    end else begin
      prime_d = prime_q + 2'd1;
    end
  end

  // Outcome of a wrong entry: either the next failure count or lockout.
  always_comb begin
    if (fail_q == FAIL_LAST) begin
      fail_state_s = ST_LOCKOUT;
      fail_next_s  = FAIL_MAX;
    end else begin
      fail_state_s = ST_IDLE;
      fail_next_s  = fail_q + 3'd1;
    end
  end

  // Next-state logic; the timer only runs in OPEN and LOCKOUT.
  always_comb begin
    state_d = state_q;
    timer_d = 16'd0;
    fail_d  = fail_q;
    case (state_q)
      ST_IDLE: begin
        if (rev_ccw_s && (code2_q == CODE0)) begin
          state_d = ST_GOT1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GOT1: begin
        if (rev_cw_s && (code2_q == CODE1)) begin
          state_d = ST_GOT2;
        end else if (rev_s) begin
          state_d = fail_state_s;
          fail_d  = fail_next_s;
        end else begin
          state_d = ST_GOT1;
        end
      end
      ST_GOT2: begin
        if (rev_ccw_s && (code2_q == CODE2)) begin
          state_d = ST_OPEN;
          fail_d  = 3'd0;
        end else if (rev_s) begin
          state_d = fail_state_s;
          fail_d  = fail_next_s;
        end else begin
          state_d = ST_GOT2;
        end
      end
      ST_OPEN: begin
        if (lock || (timer_q == OPEN_LAST)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OPEN;
          timer_d = timer_q + 16'd1;
        end
      end
      ST_LOCKOUT: begin
        if (timer_q == LOCK_LAST) begin
          state_d = ST_IDLE;
          fail_d  = 3'd0;
        end else begin
          state_d = ST_LOCKOUT;
          timer_d = timer_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        fail_d  = 3'd0;
      end
    endcase
  end

  // Output decode from the next state so the outputs register alongside it.
  always_comb begin
    unlocked_d = (state_d == ST_OPEN);
    lockout_d  = (state_d == ST_LOCKOUT);
    case (state_d)
      ST_GOT1: stage_d = 2'd1;
      ST_GOT2: stage_d = 2'd2;
      ST_OPEN: stage_d = 2'd3;
      default: stage_d = 2'd0;
    endcase
  end

  // State, history and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state_q    <= ST_IDLE;
      code1_q    <= 5'd0;
      code2_q    <= 5'd0;
      dir_q      <= 1'b1;
      prime_q    <= 2'd0;
      timer_q    <= 16'd0;
      fail_q     <= 3'd0;
      unlocked_q <= 1'b0;
      lockout_q  <= 1'b0;
      stage_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      code1_q    <= vault_code;
      code2_q    <= code1_q;
      dir_q      <= direction;
      prime_q    <= prime_d;
      timer_q    <= timer_d;
      fail_q     <= fail_d;
      unlocked_q <= unlocked_d;
      lockout_q  <= lockout_d;
      stage_q    <= stage_d;
    end
  end

  assign unlocked   = unlocked_q;
  assign lockout    = lockout_q;
  assign stage      = stage_q;
  assign fail_count = fail_q;

  combo_sequencer_chk #(
    .MAX_FAIL(MAX_FAIL)
  ) u_chk (
    .clock      (clock),
    .n_reset    (n_reset),
    .unlocked   (unlocked_q),
    .lockout    (lockout_q),
    .stage      (stage_q),
    .fail_count (fail_q)
  );

endmodule

// Output consistency properties for combo_sequencer.
module combo_sequencer_chk #(
  parameter int unsigned MAX_FAIL = 3
) (
  input logic       clock,
  input logic       n_reset,
  input logic       unlocked,
  input logic       lockout,
  input logic [1:0] stage,
  input logic [2:0] fail_count
);

  a_open_lock_excl: assert property (@(posedge clock) disable iff (!n_reset)
    !(unlocked && lockout));

  a_stage_open: assert property (@(posedge clock) disable iff (!n_reset)
    unlocked == (stage == 2'd3));

  a_fail_range: assert property (@(posedge clock) disable iff (!n_reset)
    fail_count <= 3'(MAX_FAIL));

endmodule

// File: tb/tb_combo_sequencer.sv
// Scoreboard bench for combo_sequencer: stimulus queues expected output
// snapshots with their due cycle; a monitor compares them and flags strays.
module tb_combo_sequencer;

  logic       clk = 1'b0;
  logic       n_reset, direction, lock;
  logic [4:0] vault_code;
  logic       unlocked, lockout, w_unlocked, w_lockout;
  logic [1:0] stage, w_stage;
  logic [2:0] fail_count, w_fail_count;

  always #5 clk = ~clk;

  combo_sequencer u_dut (
    .clock(clk), .n_reset(n_reset), .vault_code(vault_code), .direction(direction),
    .lock(lock), .unlocked(unlocked), .lockout(lockout), .stage(stage),
    .fail_count(fail_count)
  );

  // Second instance with CODE0 = 0 for the dial wrap-around case.
  combo_sequencer #(.CODE0(5'd0)) u_wrap (
    .clock(clk), .n_reset(n_reset), .vault_code(vault_code), .direction(direction),
    .lock(lock), .unlocked(w_unlocked), .lockout(w_lockout), .stage(w_stage),
    .fail_count(w_fail_count)
  );

  typedef struct {
    int         due;
    int         which;
    logic [6:0] exp;
    string      name;
  } exp_t;

  exp_t       sb_q[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  logic [4:0] cur;
  logic       pend;
  logic [6:0] last0 = 7'd0;
  logic [6:0] last1 = 7'd0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] snap(input logic u, input logic l,
                                      input logic [1:0] s, input logic [2:0] f);
    return {u, l, s, f};
  endfunction

  task automatic expect_at(input int which, input int due, input logic [6:0] e,
                           input string name);
    exp_t t;
    t.due = due; t.which = which; t.exp = e; t.name = name;
    sb_q.push_back(t);
  endtask

  // One dial position per cycle; direction follows one edge later, like the decoder.
  task automatic step(input logic [4:0] v);
    @(negedge clk);
    direction = pend;
    if (v == cur + 5'd1) pend = 1'b1;
    else if (v == cur - 5'd1) pend = 1'b0;
    vault_code = v;
    cur = v;
  endtask

  task automatic goto(input logic [4:0] t, input logic up);
    while (cur != t) step(up ? cur + 5'd1 : cur - 5'd1);
  endtask

  task automatic hold_until(input int t);
    while (cyc < t) step(cur);
  endtask

  // Full 12 / 7 / 25 entry; e returns the cycle OPEN should become visible.
  task automatic do_open(input bit chk, input logic [2:0] f, output int e);
    goto(5'd12, 1'b1);
    step(5'd11);
    if (chk) expect_at(0, cyc + 2, snap(1'b0, 1'b0, 2'd1, f), "stage1");
    goto(5'd7, 1'b0);
    step(5'd8);
    if (chk) expect_at(0, cyc + 2, snap(1'b0, 1'b0, 2'd2, f), "stage2");
    goto(5'd25, 1'b1);
    step(5'd24);
    e = cyc + 2;
    if (chk) expect_at(0, e, snap(1'b1, 1'b0, 2'd3, 3'd0), "open");
  endtask

  // Monitor: compare every due expectation; any unannounced output change fails.
  always @(negedge clk) begin : monitor
    logic [6:0] s0, s1, got;
    bit         h0, h1;
    int         idx;
    s0 = {unlocked, lockout, stage, fail_count};
    s1 = {w_unlocked, w_lockout, w_stage, w_fail_count};
    h0 = 1'b0;
    h1 = 1'b0;
    idx = 0;
    while (idx < sb_q.size()) begin
      if (sb_q[idx].due <= cyc) begin
        got = (sb_q[idx].which == 0) ? s0 : s1;
        if (sb_q[idx].which == 0) h0 = 1'b1; else h1 = 1'b1;
        n_checks++;
        if (sb_q[idx].due == cyc && got === sb_q[idx].exp) n_pass++;
        else $display("FAIL %s: cycle %0d got %b, expected %b at cycle %0d",
                      sb_q[idx].name, cyc, got, sb_q[idx].exp, sb_q[idx].due);
        sb_q.delete(idx);
      end else begin
        idx++;
      end
    end
    if (s0 !== last0 && !h0) begin
      n_checks++;
      $display("FAIL unexpected_change_main: cycle %0d got %b, expected %b", cyc, s0, last0);
    end
    if (s1 !== last1 && !h1) begin
      n_checks++;
      $display("FAIL unexpected_change_wrap: cycle %0d got %b, expected %b", cyc, s1, last1);
    end
    last0 = s0;
    last1 = s1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t got no finish, expected finish before it", $time);
    $fatal(1);
  end

  initial begin
    int e;
    n_reset = 1'b0; lock = 1'b0; vault_code = 5'd0; direction = 1'b1;
    cur = 5'd0; pend = 1'b1;
    expect_at(0, 2, 7'd0, "reset_main");
    expect_at(1, 2, 7'd0, "reset_wrap");
    repeat (3) step(cur);
    n_reset = 1'b1;

    // Correct entry, then timeout after 64 open cycles
    do_open(1'b1, 3'd0, e);
    expect_at(0, e + 64, 7'd0, "open_timeout");
    hold_until(e + 66);

    // Wrong second number: reverse at 9
    goto(5'd12, 1'b1);
    step(5'd11);
    expect_at(0, cyc + 2, snap(1'b0, 1'b0, 2'd1, 3'd0), "wrong_stage1");
    step(5'd10); step(5'd9); step(5'd10);
    expect_at(0, cyc + 2, snap(1'b0, 1'b0, 2'd0, 3'd1), "wrong_fail1");
    hold_until(cyc + 4);

    // Reset mid-sequence at stage 2, then an immediate 25 -> 24 step
    goto(5'd12, 1'b1);
    step(5'd11);
    expect_at(0, cyc + 2, snap(1'b0, 1'b0, 2'd1, 3'd1), "mid_stage1");
    goto(5'd7, 1'b0);
    step(5'd8);
    expect_at(0, cyc + 2, snap(1'b0, 1'b0, 2'd2, 3'd1), "mid_stage2");
    goto(5'd25, 1'b1);
    step(cur);
    n_reset = 1'b0;
    expect_at(0, cyc + 1, 7'd0, "mid_reset");
    step(5'd24);
    n_reset = 1'b1;
    hold_until(cyc + 8);

    // Three wrong second numbers -> lockout; a correct entry inside is ignored
    for (int k = 0; k < 3; k++) begin
      goto(5'd12, 1'b1);
      step(5'd11);
      expect_at(0, cyc + 2, snap(1'b0, 1'b0, 2'd1, 3'(k)), "lk_stage1");
      step(5'd10); step(5'd9); step(5'd10);
      if (k < 2) begin
        expect_at(0, cyc + 2, snap(1'b0, 1'b0, 2'd0, 3'(k + 1)), "lk_fail");
      end else begin
        e = cyc + 2;
        expect_at(0, e, snap(1'b0, 1'b1, 2'd0, 3'd3), "lockout_on");
        expect_at(0, e + 256, 7'd0, "lockout_off");
      end
    end
    begin
      int e_ign;
      int e_lock;
      e_lock = e;
      do_open(1'b0, 3'd0, e_ign);
      hold_until(e_lock + 258);
    end

    // Relock with a one-cycle lock pulse at timer = 10
    do_open(1'b1, 3'd0, e);
    expect_at(0, e + 11, 7'd0, "relock");
    hold_until(e + 10);
    lock = 1'b1;
    step(cur);
    lock = 1'b0;
    hold_until(cyc + 4);

    // Wrap-around: 30, 31, 0, reverse to 31 enters 0
    goto(5'd30, 1'b1);
    step(5'd31); step(5'd0); step(5'd31);
    expect_at(1, cyc + 2, snap(1'b0, 1'b0, 2'd1, 3'd0), "wrap_stage1");
    hold_until(cyc + 6);

    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL pending_expectations: got %0d left, expected 0", sb_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
